// File: rtl/cpu_mem_resp_pkg.sv
// Shared types and constants for the CPU memory responder.
// Holds the FSM state encoding, port select constants and default widths.
package cpu_mem_resp_pkg;

    localparam int DEF_ADDR_W = 30;
    localparam int DEF_DATA_W = 32;
    localparam int LANES      = DEF_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        D_REQ,
        D_WAIT,
        I_REQ,
        I_WAIT
    } state_t;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

endpackage

// File: rtl/mem_resp_port_capture.sv
// Capture register for one CPU port: latches a read or write request while idle
// and holds it until the responder clears it after serving.
module mem_resp_port_capture
    import cpu_mem_resp_pkg::*;
#(
    parameter int AW = DEF_ADDR_W,
    parameter int DW = DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [31:0]      addr,
    input  logic [LANES-1:0] we,
    input  logic             re,
    input  logic [DW-1:0]    din,
    output logic             req,
    output logic             valid,
    output logic             rnw,
    output logic [AW-1:0]    waddr,
    output logic [LANES-1:0] mask,
    output logic [DW-1:0]    wdata
);

    // Byte offset never reaches the word-addressed backing memory.
    logic unused_lsb;
    assign unused_lsb = ^addr[1:0];

    // A nonzero write enable wins over a simultaneous read request.
    assign req = (we != '0) | re;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            rnw   <= 1'b0;
            waddr <= '0;
            mask  <= '0;
            wdata <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load && req) begin
            valid <= 1'b1;
            rnw   <= (we == '0);
            waddr <= addr[AW+1:2];
            mask  <= we;
            wdata <= din;
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Serves the CPU dcache and icache ports through one backing-memory handshake, dcache first.
// Optional CPU_MEM_RESP_IBUF_EN adds a one-entry instruction buffer that skips repeat fetches.
module cpu_mem_responder
    import cpu_mem_resp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dcache_addr,
    input  logic [LANES-1:0]  dcache_we,
    input  logic              dcache_re,
    input  logic [DATA_W-1:0] dcache_din,
    output logic [DATA_W-1:0] dcache_dout,
    input  logic [31:0]       icache_addr,
    input  logic [LANES-1:0]  icache_we,
    input  logic              icache_re,
    input  logic [DATA_W-1:0] icache_din,
    output logic [DATA_W-1:0] instruction,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rnw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [LANES-1:0]  mem_req_mask,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state, state_nx;

    logic              idle, accept, sel, ibuf_hit;
    logic              d_req, d_valid, d_rnw, d_clear;
    logic              i_req, i_valid, i_rnw, i_clear;
    logic [ADDR_W-1:0] d_addr, i_addr;
    logic [LANES-1:0]  d_mask, i_mask;
    logic [DATA_W-1:0] d_wdata, i_wdata;

    assign idle    = (state == IDLE);
    assign accept  = mem_req_valid & mem_req_ready;
    assign d_clear = (state == D_REQ && accept && !d_rnw) || (state == D_WAIT && mem_rdata_valid);
    assign i_clear = (state == I_REQ && accept && !i_rnw) || (state == I_WAIT && mem_rdata_valid);

    mem_resp_port_capture #(.AW(ADDR_W), .DW(DATA_W)) u_dcap (
        .clk(clk), .rst(rst), .load(idle), .clear(d_clear),
        .addr(dcache_addr), .we(dcache_we), .re(dcache_re), .din(dcache_din),
        .req(d_req), .valid(d_valid), .rnw(d_rnw), .waddr(d_addr), .mask(d_mask), .wdata(d_wdata)
    );

    mem_resp_port_capture #(.AW(ADDR_W), .DW(DATA_W)) u_icap (
        .clk(clk), .rst(rst), .load(idle && !ibuf_hit), .clear(i_clear),
        .addr(icache_addr), .we(icache_we), .re(icache_re), .din(icache_din),
        .req(i_req), .valid(i_valid), .rnw(i_rnw), .waddr(i_addr), .mask(i_mask), .wdata(i_wdata)
    );

`ifdef CPU_MEM_RESP_IBUF_EN
    logic [ADDR_W-1:0] ibuf_tag;
    logic              ibuf_valid;

    // Only a lone fetch may be satisfied from the buffer; anything else walks the FSM.
    assign ibuf_hit = ibuf_valid && icache_re && (icache_we == '0) && !d_req &&
                      (icache_addr[ADDR_W+1:2] == ibuf_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ibuf_tag   <= '0;
            ibuf_valid <= 1'b0;
        end else if (state == I_WAIT && mem_rdata_valid) begin
            ibuf_tag   <= i_addr;
            ibuf_valid <= 1'b1;
        end else if (accept && !mem_req_rnw && mem_req_addr == ibuf_tag) begin
            ibuf_valid <= 1'b0;
        end
    end
`else
    assign ibuf_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        stall         = (state != IDLE);
        mem_req_valid = (state == D_REQ && d_valid) || (state == I_REQ && i_valid);
        sel           = (state == I_REQ) ? PORT_I : PORT_D;
        case (state)
            IDLE:    if (d_req) state_nx = D_REQ;
                     else if (i_req && !ibuf_hit) state_nx = I_REQ;
            D_REQ:   if (accept) state_nx = d_rnw ? D_WAIT : (i_valid ? I_REQ : IDLE);
            D_WAIT:  if (mem_rdata_valid) state_nx = i_valid ? I_REQ : IDLE;
            I_REQ:   if (accept) state_nx = i_rnw ? I_WAIT : IDLE;
            I_WAIT:  if (mem_rdata_valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_req_rnw   = (sel == PORT_I) ? i_rnw   : d_rnw;
    assign mem_req_addr  = (sel == PORT_I) ? i_addr  : d_addr;
    assign mem_req_wdata = (sel == PORT_I) ? i_wdata : d_wdata;
    assign mem_req_mask  = mem_req_rnw ? '0 : ((sel == PORT_I) ? i_mask : d_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcache_dout <= '0;
            instruction <= '0;
        end else begin
            if (state == D_WAIT && mem_rdata_valid) dcache_dout <= mem_rdata;
            if (state == I_WAIT && mem_rdata_valid) instruction <= mem_rdata;
        end
    end

endmodule
